// File: rtl/ex_operand_stage_pkg.sv
// Shared types and constants for the ID/EX operand stage.
// Opcodes, ALU op codes, immediate kinds and the ID/EX register bundle.
package ex_operand_stage_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_type_e;

    typedef struct packed {
        logic        valid;
        logic [3:0]  alu_op;
        logic [31:0] data1;
        logic [31:0] data2;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        reg_we;
        logic        is_load;
        logic        is_store;
        logic [31:0] pc;
        logic        illegal;
    } id_ex_t;

    function automatic imm_type_e imm_type(input logic [6:0] opc);
        imm_type_e t;
        t = IMM_NONE;
        case (opc)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: t = IMM_I;
            OPC_STORE:                      t = IMM_S;
            OPC_BRANCH:                     t = IMM_B;
            OPC_LUI, OPC_AUIPC:             t = IMM_U;
            OPC_JAL:                        t = IMM_J;
            default:                        t = IMM_NONE;
        endcase
        return t;
    endfunction

    // x0 is never a forwarding source.
    function automatic logic fwd_hit(
        input logic       we,
        input logic [4:0] rd,
        input logic [4:0] rs
    );
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/ex_operand_stage_if.sv
// ID-side request, forwarding taps, stage control and EX-side results.
// The stage is the slave; the surrounding pipeline is the master.
interface ex_operand_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            id_valid;
    logic [31:0]     id_inst;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;

    logic            mem_fwd_we;
    logic [4:0]      mem_fwd_rd;
    logic [XLEN-1:0] mem_fwd_data;
    logic            wb_fwd_we;
    logic [4:0]      wb_fwd_rd;
    logic [XLEN-1:0] wb_fwd_data;

    logic            stall;
    logic            flush;

    logic            ex_valid;
    logic [3:0]      ex_alu_op;
    logic [XLEN-1:0] ex_data1;
    logic [XLEN-1:0] ex_data2;
    logic [XLEN-1:0] ex_store_data;
    logic [4:0]      ex_rd;
    logic            ex_reg_we;
    logic            ex_is_load;
    logic            ex_is_store;
    logic [XLEN-1:0] ex_pc;
    logic            ex_illegal;
    logic            load_use_hazard;

    modport master (
        output id_valid, id_inst, id_pc, id_rs1_data, id_rs2_data,
        output mem_fwd_we, mem_fwd_rd, mem_fwd_data,
        output wb_fwd_we, wb_fwd_rd, wb_fwd_data,
        output stall, flush,
        input  ex_valid, ex_alu_op, ex_data1, ex_data2, ex_store_data,
        input  ex_rd, ex_reg_we, ex_is_load, ex_is_store, ex_pc,
        input  ex_illegal, load_use_hazard
    );

    modport slave (
        input  id_valid, id_inst, id_pc, id_rs1_data, id_rs2_data,
        input  mem_fwd_we, mem_fwd_rd, mem_fwd_data,
        input  wb_fwd_we, wb_fwd_rd, wb_fwd_data,
        input  stall, flush,
        output ex_valid, ex_alu_op, ex_data1, ex_data2, ex_store_data,
        output ex_rd, ex_reg_we, ex_is_load, ex_is_store, ex_pc,
        output ex_illegal, load_use_hazard
    );
endinterface

// File: rtl/ex_operand_stage_imm_gen.sv
// RV32I immediate generator: sign-extended immediate chosen by opcode.
// Purely combinational; unknown opcodes yield zero.
module ex_operand_stage_imm_gen
    import ex_operand_stage_pkg::*;
(
    input  logic [31:0] inst,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (imm_type(inst[6:0]))
            IMM_I: imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S: imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B: imm = {{19{inst[31]}}, inst[31], inst[7],
                          inst[30:25], inst[11:8], 1'b0};
            IMM_U: imm = {inst[31:12], 12'b0};
            IMM_J: imm = {{11{inst[31]}}, inst[31], inst[19:12],
                          inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: decode to ALU op, forward and select operands,
// register the result for EX and flag load-use hazards back to ID.
module ex_operand_stage
    import ex_operand_stage_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
    input logic              clk,
    input logic              rst,
    ex_operand_stage_if.slave bus
);

    localparam logic [XLEN-1:0] LINK_OFS = XLEN'(4);

    logic [6:0]      opc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      f3;
    logic            f7b;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    assign opc = bus.id_inst[6:0];
    assign rd  = bus.id_inst[11:7];
    assign f3  = bus.id_inst[14:12];
    assign rs1 = bus.id_inst[19:15];
    assign rs2 = bus.id_inst[24:20];
    assign f7b = bus.id_inst[30];

    ex_operand_stage_imm_gen u_imm_gen (
        .inst (bus.id_inst),
        .imm  (imm)
    );

    // The closer stage (EX/MEM) holds the younger value, so it wins.
    always_comb begin
        rs1_val = bus.id_rs1_data;
        if (rs1 == 5'd0)
            rs1_val = '0;
        else if (fwd_hit(bus.mem_fwd_we, bus.mem_fwd_rd, rs1))
            rs1_val = bus.mem_fwd_data;
        else if (fwd_hit(bus.wb_fwd_we, bus.wb_fwd_rd, rs1))
            rs1_val = bus.wb_fwd_data;
    end

    always_comb begin
        rs2_val = bus.id_rs2_data;
        if (rs2 == 5'd0)
            rs2_val = '0;
        else if (fwd_hit(bus.mem_fwd_we, bus.mem_fwd_rd, rs2))
            rs2_val = bus.mem_fwd_data;
        else if (fwd_hit(bus.wb_fwd_we, bus.wb_fwd_rd, rs2))
            rs2_val = bus.wb_fwd_data;
    end

    logic [3:0]      dec_op;
    logic [XLEN-1:0] dec_a;
    logic [XLEN-1:0] dec_b;
    logic            dec_we;
    logic            dec_ld;
    logic            dec_st;
    logic            dec_ill;
    logic            rs1_used;
    logic            rs2_used;

    always_comb begin
        dec_op   = ALU_ADD;
        dec_a    = rs1_val;
        dec_b    = imm;
        dec_we   = 1'b0;
        dec_ld   = 1'b0;
        dec_st   = 1'b0;
        dec_ill  = 1'b0;
        rs1_used = 1'b1;
        rs2_used = 1'b0;
        case (opc)
            OPC_OP: begin
                dec_op   = {f7b, f3};
                dec_b    = rs2_val;
                dec_we   = 1'b1;
                rs2_used = 1'b1;
            end
            OPC_OP_IMM: begin
                // Only shifts use funct7[5]; other I-ops carry imm bits there.
                dec_op = {(f3 == 3'b101) & f7b, f3};
                dec_we = 1'b1;
            end
            OPC_LOAD: begin
                dec_ld = 1'b1;
                dec_we = 1'b1;
            end
            OPC_STORE: begin
                dec_st   = 1'b1;
                rs2_used = 1'b1;
            end
            OPC_LUI: begin
                dec_a    = '0;
                dec_we   = 1'b1;
                rs1_used = 1'b0;
            end
            OPC_AUIPC: begin
                dec_a    = bus.id_pc;
                dec_we   = 1'b1;
                rs1_used = 1'b0;
            end
            OPC_JAL: begin
                dec_a    = bus.id_pc;
                dec_b    = LINK_OFS;
                dec_we   = 1'b1;
                rs1_used = 1'b0;
            end
            OPC_JALR: begin
                dec_a  = bus.id_pc;
                dec_b  = LINK_OFS;
                dec_we = 1'b1;
            end
            OPC_BRANCH: begin
                dec_a    = bus.id_pc;
                rs2_used = 1'b1;
            end
            default: dec_ill = 1'b1;
        endcase
    end

    id_ex_t ex_q;
    id_ex_t ex_d;

    always_comb begin
        ex_d = ex_q;
        if (bus.flush) begin
            ex_d.valid    = 1'b0;
            ex_d.reg_we   = 1'b0;
            ex_d.is_load  = 1'b0;
            ex_d.is_store = 1'b0;
            ex_d.illegal  = 1'b0;
        end else if (!bus.stall) begin
            ex_d.valid      = bus.id_valid;
            ex_d.alu_op     = dec_op;
            ex_d.data1      = dec_a;
            ex_d.data2      = dec_b;
            ex_d.store_data = rs2_val;
            ex_d.rd         = rd;
            ex_d.reg_we     = bus.id_valid & dec_we & (rd != 5'd0);
            ex_d.is_load    = bus.id_valid & dec_ld;
            ex_d.is_store   = bus.id_valid & dec_st;
            ex_d.pc         = bus.id_pc;
            ex_d.illegal    = bus.id_valid & dec_ill;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q    <= '0;
            ex_q.pc <= RESET_PC;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign bus.load_use_hazard = bus.id_valid & ex_q.valid & ex_q.is_load
                               & (ex_q.rd != 5'd0)
                               & ((rs1_used & (ex_q.rd == rs1))
                                | (rs2_used & (ex_q.rd == rs2)));

    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_alu_op     = ex_q.alu_op;
    assign bus.ex_data1      = ex_q.data1;
    assign bus.ex_data2      = ex_q.data2;
    assign bus.ex_store_data = ex_q.store_data;
    assign bus.ex_rd         = ex_q.rd;
    assign bus.ex_reg_we     = ex_q.reg_we;
    assign bus.ex_is_load    = ex_q.is_load;
    assign bus.ex_is_store   = ex_q.is_store;
    assign bus.ex_pc         = ex_q.pc;
    assign bus.ex_illegal    = ex_q.illegal;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: expectations queued at issue,
// popped and compared one cycle later.
module tb_ex_operand_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0080;
    localparam logic [6:0]  O_OP   = 7'b0110011;
    localparam logic [6:0]  O_IMM  = 7'b0010011;
    localparam logic [6:0]  O_LD   = 7'b0000011;
    localparam logic [6:0]  O_LUI  = 7'b0110111;
    localparam logic [6:0]  O_AUI  = 7'b0010111;
    localparam logic [6:0]  O_JAL  = 7'b1101111;

    logic clk;
    logic rst;

    ex_operand_stage_if bus();

    ex_operand_stage #(
        .XLEN     (32),
        .RESET_PC (RST_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       tag;
        logic        v;
        logic [3:0]  op;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        we;
        logic        ld;
        logic        st;
        logic        il;
        logic [31:0] pc;
        logic        ctrl_only;
        logic        d2_lo5;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(
        input string tag, input logic v, input logic [3:0] op,
        input logic [31:0] d1, input logic [31:0] d2,
        input logic [31:0] sd, input logic [4:0] rd,
        input logic we, input logic ld, input logic st,
        input logic il, input logic [31:0] pc
    );
        exp_t e;
        e.tag = tag; e.v = v; e.op = op;
        e.d1 = d1; e.d2 = d2; e.sd = sd; e.rd = rd;
        e.we = we; e.ld = ld; e.st = st; e.il = il; e.pc = pc;
        e.ctrl_only = 1'b0;
        e.d2_lo5 = 1'b0;
        return e;
    endfunction

    function automatic logic [31:0] enc_r(
        input logic [6:0] f7, input logic [4:0] s2, input logic [4:0] s1,
        input logic [2:0] f3, input logic [4:0] d, input logic [6:0] op);
        return {f7, s2, s1, f3, d, op};
    endfunction

    function automatic logic [31:0] enc_i(
        input logic [11:0] im, input logic [4:0] s1, input logic [2:0] f3,
        input logic [4:0] d, input logic [6:0] op);
        return {im, s1, f3, d, op};
    endfunction

    function automatic logic [31:0] enc_s(
        input logic [11:0] im, input logic [4:0] s2, input logic [4:0] s1);
        return {im[11:5], s2, s1, 3'b010, im[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(
        input logic [12:0] im, input logic [4:0] s2, input logic [4:0] s1);
        return {im[12], im[10:5], s2, s1, 3'b000, im[4:1], im[11],
                7'b1100011};
    endfunction

    task automatic cmp_ex(input exp_t e);
        chk({e.tag, ".valid"}, 32'(bus.ex_valid), 32'(e.v));
        chk({e.tag, ".op"}, 32'(bus.ex_alu_op), 32'(e.op));
        chk({e.tag, ".rd"}, 32'(bus.ex_rd), 32'(e.rd));
        chk({e.tag, ".we"}, 32'(bus.ex_reg_we), 32'(e.we));
        chk({e.tag, ".ld"}, 32'(bus.ex_is_load), 32'(e.ld));
        chk({e.tag, ".st"}, 32'(bus.ex_is_store), 32'(e.st));
        chk({e.tag, ".ill"}, 32'(bus.ex_illegal), 32'(e.il));
        if (!e.ctrl_only) begin
            chk({e.tag, ".d1"}, bus.ex_data1, e.d1);
            if (e.d2_lo5)
                chk({e.tag, ".shamt"}, 32'(bus.ex_data2[4:0]), e.d2);
            else
                chk({e.tag, ".d2"}, bus.ex_data2, e.d2);
            chk({e.tag, ".sd"}, bus.ex_store_data, e.sd);
            chk({e.tag, ".pc"}, bus.ex_pc, e.pc);
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            cmp_ex(e);
        end
    endtask

    task automatic set_id(input logic v, input logic [31:0] inst,
                          input logic [31:0] pc, input logic [31:0] r1,
                          input logic [31:0] r2);
        bus.id_valid    = v;
        bus.id_inst     = inst;
        bus.id_pc       = pc;
        bus.id_rs1_data = r1;
        bus.id_rs2_data = r2;
    endtask

    task automatic set_fwd(input logic mwe, input logic [4:0] mrd,
                           input logic [31:0] md, input logic wwe,
                           input logic [4:0] wrd, input logic [31:0] wd);
        bus.mem_fwd_we   = mwe;
        bus.mem_fwd_rd   = mrd;
        bus.mem_fwd_data = md;
        bus.wb_fwd_we    = wwe;
        bus.wb_fwd_rd    = wrd;
        bus.wb_fwd_data  = wd;
    endtask

    task automatic issue(input logic v, input logic [31:0] inst,
                         input logic [31:0] pc, input logic [31:0] r1,
                         input logic [31:0] r2, input exp_t e);
        set_id(v, inst, pc, r1, r2);
        sb.push_back(e);
        step();
    endtask

    exp_t e;
    exp_t held;

    initial begin
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        set_id(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", 32'(bus.ex_valid), 32'd0);
        chk("rst.op", 32'(bus.ex_alu_op), 32'd0);
        chk("rst.d1", bus.ex_data1, 32'd0);
        chk("rst.d2", bus.ex_data2, 32'd0);
        chk("rst.sd", bus.ex_store_data, 32'd0);
        chk("rst.rd", 32'(bus.ex_rd), 32'd0);
        chk("rst.we", 32'(bus.ex_reg_we), 32'd0);
        chk("rst.ld", 32'(bus.ex_is_load), 32'd0);
        chk("rst.st", 32'(bus.ex_is_store), 32'd0);
        chk("rst.ill", 32'(bus.ex_illegal), 32'd0);
        chk("rst.pc", bus.ex_pc, RST_PC);
        rst = 1'b0;

        // R-type and shift-immediate decode
        issue(1, enc_r(7'h00, 2, 1, 3'b000, 3, O_OP), 32'h10, 7, 5,
              mk("add", 1, 4'b0000, 7, 5, 5, 3, 1, 0, 0, 0, 32'h10));
        issue(1, enc_r(7'h20, 2, 1, 3'b000, 3, O_OP), 32'h14, 20, 5,
              mk("sub", 1, 4'b1000, 20, 5, 5, 3, 1, 0, 0, 0, 32'h14));
        e = mk("srai", 1, 4'b1101, 32'hF0, 3, 32'h77, 5, 1, 0, 0, 0,
               32'h18);
        e.d2_lo5 = 1'b1;
        issue(1, enc_i(12'h403, 6, 3'b101, 5, O_IMM), 32'h18, 32'hF0,
              32'h77, e);
        issue(1, enc_i(12'h400, 6, 3'b111, 5, O_IMM), 32'h1C, 32'h33,
              32'h1, mk("andi", 1, 4'b0111, 32'h33, 32'h400, 0, 5, 1, 0,
                        0, 0, 32'h1C));
        issue(1, enc_i(12'hFFF, 6, 3'b000, 5, O_IMM), 32'h1C, 10, 5,
              mk("addi_neg", 1, 4'b0000, 10, 32'hFFFF_FFFF, 5, 5, 1, 0,
                 0, 0, 32'h1C));

        // Forwarding priority and x0 handling
        set_fwd(1, 4, 32'h11, 1, 4, 32'h22);
        issue(1, enc_r(7'h00, 2, 4, 3'b000, 7, O_OP), 32'h1C, 32'h99, 3,
              mk("fwd_mem", 1, 0, 32'h11, 3, 3, 7, 1, 0, 0, 0, 32'h1C));
        set_fwd(0, 4, 32'h11, 1, 4, 32'h22);
        issue(1, enc_r(7'h00, 2, 4, 3'b000, 7, O_OP), 32'h1C, 32'h99, 3,
              mk("fwd_wb", 1, 0, 32'h22, 3, 3, 7, 1, 0, 0, 0, 32'h1C));
        set_fwd(1, 0, 32'h11, 1, 0, 32'h22);
        issue(1, enc_r(7'h00, 2, 0, 3'b000, 7, O_OP), 32'h1C, 0, 3,
              mk("fwd_x0", 1, 0, 0, 3, 3, 7, 1, 0, 0, 0, 32'h1C));
        issue(1, enc_r(7'h00, 2, 0, 3'b000, 7, O_OP), 32'h1C, 32'h55, 3,
              mk("x0_rf", 1, 0, 0, 3, 3, 7, 1, 0, 0, 0, 32'h1C));
        set_fwd(0, 0, 32'h0, 1, 5, 32'hABCD);
        issue(1, enc_s(12'd8, 5, 1), 32'h20, 32'h100, 32'h5,
              mk("sw_fwd", 1, 0, 32'h100, 8, 32'hABCD, 8, 0, 0, 1, 0,
                 32'h20));
        set_fwd(0, 0, 32'h0, 0, 0, 32'h0);

        // Load-use hazard against a load sitting in EX
        issue(1, enc_i(12'h000, 1, 3'b010, 8, O_LD), 32'h24, 32'h200, 9,
              mk("lw", 1, 0, 32'h200, 0, 0, 8, 1, 1, 0, 0, 32'h24));
        set_id(1, enc_r(7'h00, 2, 8, 3'b000, 9, O_OP), 32'h28, 1, 2);
        #1 chk("haz_rs1", 32'(bus.load_use_hazard), 32'd1);
        set_id(1, enc_r(7'h00, 2, 1, 3'b000, 9, O_OP), 32'h28, 1, 2);
        #1 chk("haz_none", 32'(bus.load_use_hazard), 32'd0);
        set_id(1, enc_s(12'd0, 8, 1), 32'h28, 1, 2);
        #1 chk("haz_st_rs2", 32'(bus.load_use_hazard), 32'd1);
        set_id(1, {20'h00040, 5'd9, O_LUI}, 32'h28, 1, 2);
        #1 chk("haz_lui", 32'(bus.load_use_hazard), 32'd0);
        set_id(0, enc_r(7'h00, 2, 8, 3'b000, 9, O_OP), 32'h28, 1, 2);
        #1 chk("haz_idinv", 32'(bus.load_use_hazard), 32'd0);

        // Controller response: stall ID, flush this stage
        set_id(1, enc_r(7'h00, 2, 8, 3'b000, 9, O_OP), 32'h28, 1, 2);
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        sb.push_back(mk("flush", 0, 0, 32'h200, 0, 0, 8, 0, 0, 0, 0,
                        32'h24));
        step();
        chk("haz_after", 32'(bus.load_use_hazard), 32'd0);
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        held = mk("stall", 1, 0, 32'h300, 2, 2, 9, 1, 0, 0, 0, 32'h28);
        issue(1, enc_r(7'h00, 2, 8, 3'b000, 9, O_OP), 32'h28, 32'h300, 2,
              mk("add_rel", 1, 0, 32'h300, 2, 2, 9, 1, 0, 0, 0, 32'h28));

        // Stall holds every register for three cycles
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++)
            issue(1, enc_r(7'h20, 3, 2, 3'b000, 1, O_OP), 32'h99C + i,
                  32'h1, 32'h1, held);
        bus.stall = 1'b0;

        // Upper-immediate, jump, branch, illegal and bubble
        issue(1, {20'h01000, 5'd10, O_AUI}, 32'h100, 32'h5, 32'h44,
              mk("auipc", 1, 0, 32'h100, 32'h0100_0000, 32'h44, 10, 1, 0,
                 0, 0, 32'h100));
        issue(1, {20'h00000, 5'd1, O_JAL}, 32'h40, 32'h5, 32'h6,
              mk("jal", 1, 0, 32'h40, 4, 0, 1, 1, 0, 0, 0, 32'h40));
        issue(1, enc_b(13'h1FF8, 2, 1), 32'h200, 5, 6,
              mk("beq", 1, 0, 32'h200, 32'hFFFF_FFF8, 6, 25, 0, 0, 0, 0,
                 32'h200));
        issue(1, {20'h12345, 5'd0, O_LUI}, 32'h300, 32'h9, 32'h7,
              mk("lui_x0", 1, 0, 0, 32'h1234_5000, 7, 0, 0, 0, 0, 0,
                 32'h300));
        e = mk("illegal", 1, 0, 0, 0, 0, 4, 0, 0, 0, 1, 32'h304);
        e.ctrl_only = 1'b1;
        issue(1, {20'h00000, 5'd4, 7'b1111111}, 32'h304, 1, 2, e);
        e = mk("bubble", 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 32'h308);
        e.ctrl_only = 1'b1;
        issue(0, enc_r(7'h00, 2, 1, 3'b000, 3, O_OP), 32'h308, 1, 2, e);
        issue(1, enc_r(7'h00, 2, 1, 3'b110, 3, O_OP), 32'h30C, 1, 2,
              mk("or", 1, 4'b0110, 1, 2, 2, 3, 1, 0, 0, 0, 32'h30C));

        // Asynchronous reset between clock edges
        rst = 1'b1;
        #2;
        chk("arst.valid", 32'(bus.ex_valid), 32'd0);
        chk("arst.op", 32'(bus.ex_alu_op), 32'd0);
        chk("arst.d1", bus.ex_data1, 32'd0);
        chk("arst.we", 32'(bus.ex_reg_we), 32'd0);
        chk("arst.pc", bus.ex_pc, RST_PC);
        #2;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX boundary stage: the producer side of the ALU interface.
- Decodes the RV32I instruction issued from ID into the 4-bit ALU op code and selects and forwards both operands.
- Registers the decoded result so EX sees alu_op/data1/data2 one cycle after issue.
- Also flags load-use hazards back to the ID/IF control.

Parameters:
- XLEN, 32, datapath width.
- RESET_PC, 32'h0000_0000, reset value of the registered ex_pc.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_inst  in  32  instruction word
- id_pc  in  32  instruction PC
- id_rs1_data  in  32  register-file read, rs1
- id_rs2_data  in  32  register-file read, rs2
- mem_fwd_we  in  1  EX/MEM stage will write rd
- mem_fwd_rd  in  5  EX/MEM destination
- mem_fwd_data  in  32  EX/MEM result
- wb_fwd_we  in  1  MEM/WB stage will write rd
- wb_fwd_rd  in  5  MEM/WB destination
- wb_fwd_data  in  32  MEM/WB result
- stall  in  1  hold stage contents
- flush  in  1  kill stage contents (branch redirect)
- ex_valid  out  1  registered valid
- ex_alu_op  out  4  ALU op code
- ex_data1  out  32  ALU operand 1
- ex_data2  out  32  ALU operand 2
- ex_store_data  out  32  forwarded rs2 for stores
- ex_rd  out  5  destination register
- ex_reg_we  out  1  writes rd
- ex_is_load  out  1  load instruction
- ex_is_store  out  1  store instruction
- ex_pc  out  32  PC of the EX instruction
- ex_illegal  out  1  unsupported opcode
- load_use_hazard  out  1  combinational; ID must stall one cycle

Behaviour:
- Reset (async, rst=1):
  - ex_valid, ex_reg_we, ex_is_load, ex_is_store and ex_illegal are 0.
  - ex_alu_op is 4'b0000; ex_data1, ex_data2, ex_store_data and ex_rd are 0.
  - ex_pc is RESET_PC.
- ALU op codes:
  - ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
- Latency: 1 cycle. Values on the id_* ports at edge N appear on the ex_* outputs after edge N.
- Priority at the clock edge: flush > stall > load.
  - flush=1: ex_valid, ex_reg_we, ex_is_load, ex_is_store and ex_illegal all go to 0. Data fields are don't-care but hold their previous values.
  - stall=1 with flush=0: every ex_* register holds its value.
  - Otherwise: load the decoded result; ex_valid = id_valid.
  - id_valid=0 loads a bubble with all control bits 0.
- Decode by opcode:
  - OP (0110011): alu_op = {funct7[5], funct3}; data1 = rs1; data2 = rs2; reg_we = 1.
  - OP-IMM (0010011): alu_op = {funct3==101 ? funct7[5] : 0, funct3}; data2 = sign-extended I-immediate. The shift amount is taken from imm[4:0] by the ALU.
  - LOAD: ADD rs1 + imm_I; is_load = 1; reg_we = 1.
  - STORE: ADD rs1 + imm_S; is_store = 1; reg_we = 0.
  - LUI: ADD 0 + imm_U.
  - AUIPC: ADD pc + imm_U.
  - JAL/JALR: ADD pc + 4, producing the link value; reg_we = 1.
  - BRANCH: ADD pc + imm_B, producing the target; reg_we = 0.
  - Any other opcode: ex_illegal = 1, reg_we = 0, alu_op ADD.
  - reg_we is forced to 0 when rd = x0.
- Forwarding, applied to rs1 and rs2 independently before operand selection:
  - EX/MEM match wins over MEM/WB.
  - A match requires the stage's we=1 and rd equal to the source register with rd != 0.
  - No match: use the register-file data.
  - A source of x0 always reads 0.
- load_use_hazard = id_valid & ex_valid & ex_is_load & ex_rd != 0 & (ex_rd == rs1 used | ex_rd == rs2 used).
  - rs2 counts as used only for OP, STORE and BRANCH.
  - rs1 is not used for LUI, AUIPC or JAL.
  - The hazard output is not itself gated by stall. The controller asserts stall on ID and flush on this stage in the same cycle, inserting a bubble.
- Reset asserted mid-operation clears the stage immediately, with no clock needed.

Decomposition:
- Constants in define.vh:
  - Opcodes OP/OP_IMM/LOAD/STORE/LUI/AUIPC/JAL/JALR/BRANCH.
  - ALU op codes ALU_ADD..ALU_AND as above.
- Sub-module imm_gen: combinational; id_inst in, 32-bit sign-extended immediate out. Type is selected by opcode (I/S/B/U/J).
- Forwarding muxes and decode stay in this module.

Test Plan:
- Reset: rst=1 mid-run, no clock edge → ex_valid=0, ex_alu_op=0000, ex_data1=0, ex_pc=RESET_PC.
- Decode of add x3,x1,x2, then sub, then srai x5,x6,3:
  - add with rs1=7, rs2=5 → next cycle alu_op=0000, data1=7, data2=5, rd=3, reg_we=1.
  - sub → alu_op=1000.
  - srai x5,x6,3 → alu_op=1101, data2=3.
- Forwarding: rs1=x4 with mem_fwd (we=1, rd=4, data=0x11) and wb_fwd (we=1, rd=4, data=0x22) → data1=0x11. Same case with rd=0 in both stages and register file giving 0 → data1=0.
- Load-use: lw x8,0(x1) in EX, ID issues add x9,x8,x2 with id_valid=1 → load_use_hazard=1. With ID issuing add x9,x1,x2 instead → load_use_hazard=0.
- Stall and flush:
  - stall=1 for 3 cycles → all outputs held.
  - stall=1 together with flush=1 → ex_valid=0, ex_reg_we=0 after the edge.
- Misc decode:
  - auipc with pc=0x100, imm=0x1000 → data1=0x100, data2=0x0100_0000.
  - jal at pc=0x40 → data1=0x40, data2=4.
  - Opcode 1111111 → ex_illegal=1, ex_reg_we=0.
